f_to_int: RTL and testbench
===========================

# f_to_int

Sequential IEEE-754 single-precision to 32-bit signed integer converter. It consumes the packed floats produced by the floating-point arithmetic blocks (e.g. the adder result word) and returns a two's-complement integer plus exception flags. The magnitude is aligned by an iterative one-bit-per-cycle shifter behind a valid/ready handshake on both sides. Default rounding is truncation toward zero.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data holds an operand
- in_ready  out  1  block can accept; combinational, equals (state == IDLE)
- in_data  in  32  IEEE-754 single {sign, exp[7:0], mant[22:0]}
- out_valid  out  1  out_data/out_flags valid; registered
- out_ready  in  1  consumer accepts result
- out_data  out  32  signed integer result; registered
- out_flags  out  3  {invalid, overflow, inexact}; registered

## Operation
- FSM states: IDLE, SHIFT, SIGN, DONE. Transfers: in = in_valid & in_ready; out = out_valid & out_ready.
- On input transfer, decode e = exp − 127, and latch sign, count cnt, direction and mag = {8'b0, 1'b1, mant}.
- Special cases go straight to DONE:
  - exp = 255, mant ≠ 0 (NaN): 0x8000_0000, flags 3'b100.
  - exp = 255, mant = 0 (±inf): saturate, flags 3'b010.
  - e ≥ 31: saturate, flags 3'b010. Exception: exactly −2^31 (0xCF00_0000) gives 0x8000_0000, flags 3'b000.
  - e < 0 (includes zero and denormals): 0, inexact = (exp|mant) ≠ 0.
  - Saturation values: +0x7FFF_FFFF, −0x8000_0000.
- Normal case (0 ≤ e ≤ 30):
  - e ≥ 23: left shift, cnt = e − 23.
  - e < 23: right shift, cnt = 23 − e.
  - If cnt = 0 go to SIGN, else go to SHIFT.
- SHIFT: shift mag one bit per cycle and decrement cnt. On right shifts, OR each bit shifted out into a sticky register. Go to SIGN in the cycle cnt goes 1→0.
- SIGN: out_data = sign ? −mag : mag. out_flags = {0, 0, sticky}. Go to DONE.
- DONE: out_valid = 1. out_data and out_flags are held stable until the output transfer, then the FSM returns to IDLE.
- No input is accepted outside IDLE. There is a single operand in flight; no overlap.

## Timing
- Reset values: out_valid 0, out_data 0, out_flags 0, state IDLE. in_ready is 1 during and after reset.
- Let edge 0 be the input-transfer edge. out_valid rises:
  - after edge 0 for special cases;
  - after edge cnt+1 for normal cases, so 1.0 (cnt 23) → edge 24 and 2^23 (cnt 0) → edge 1.
- After the output transfer edge, in_ready = 1 in the next cycle. There is a minimum one-cycle bubble between results.
- out_ready may be held low indefinitely; outputs stay frozen while it is.
- rstn asserted mid-operation aborts the conversion immediately. The FSM returns to IDLE, out_valid = 0, and the in-flight operand is discarded with no result.
- in_data is sampled only at the transfer edge. Changes at any other time are ignored.

## Configuration
- F_TO_INT_ROUND_NEAREST_EN, defined: round-to-nearest-even.
  - The normal path extends to e = −1: exp 126, cnt 24, right shift.
  - The last bit shifted out is kept as guard; earlier shifted-out bits feed sticky.
  - In SIGN, add 1 to mag before negation when guard & (sticky | mag[0]).
  - inexact = guard | sticky.
  - Latency is unchanged: cnt+1 edges, so e = −1 takes 25 edges.
- Not defined: truncation toward zero; e = −1 takes the e < 0 special path.

## Test plan
- 0x3F80_0000 (1.0), out_ready = 1 → out_data 0x0000_0001, flags 000; out_valid first high after edge 24.
- 0xC2F6_E979 (−123.456) → 0xFFFF_FF85, flags 001.
- Saturation and exact minimum:
  - 0x4F00_0000 → 0x7FFF_FFFF, flags 010.
  - 0xCF00_0000 → 0x8000_0000, flags 000.
  - 0xFF80_0000 → 0x8000_0000, flags 010.
  - 0x7FC0_0000 → 0x8000_0000, flags 100.
  - Each special case is valid after edge 0.
- Backpressure: 0x4B00_0000 (2^23) with out_ready low for 5 cycles:
  - out_data 0x0080_0000 is held stable throughout and in_ready stays 0.
  - After the transfer, in_ready = 1 one cycle later.
- Reset mid-conversion: drop rstn 10 cycles after accepting 1.0 → out_valid 0, in_ready 1, and no result is ever produced.
- Rounding, with and without the macro:
  - 0x4020_0000 (2.5) → 2 in both modes.
  - 0x4060_0000 (3.5) → 3 truncated, 4 with macro.
  - 0x3F40_0000 (0.75) → 0 flags 001 truncated; 1 flags 001 with macro.

Source files
------------

// File: rtl/f_to_int.sv
// f_to_int: sequential IEEE-754 single-precision to 32-bit signed integer converter.
// The magnitude is aligned one bit per cycle behind valid/ready handshakes on both sides.
// Default rounding truncates toward zero. Defining F_TO_INT_ROUND_NEAREST_EN selects
// round-to-nearest-even and extends the normal path down to exponent 126 (value in [0.5, 1)).
module f_to_int (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Smallest biased exponent that still takes the shifting path.
`ifdef F_TO_INT_ROUND_NEAREST_EN
  localparam logic [7:0] MIN_EXP = 8'd126;
`else
  localparam logic [7:0] MIN_EXP = 8'd127;
`endif

  localparam logic [7:0] EXP_ALIGN = 8'd150;  // 127 + 23: integer point sits at mantissa LSB
  localparam logic [7:0] EXP_SAT   = 8'd158;  // 127 + 31: first exponent that cannot fit

  state_t      state, state_next;

  logic        sign_q;
  logic        left_q;
  logic [4:0]  cnt_q;
  logic [31:0] mag_q;
  logic        sticky_q;
`ifdef F_TO_INT_ROUND_NEAREST_EN
  logic        guard_q;
`endif

  // Operand decode
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [22:0] mant_in;
  logic        left_in;
  logic [4:0]  cnt_in;
  logic        special;
  logic [31:0] spec_data;
  logic [2:0]  spec_flags;

  logic        in_xfer;
  logic        out_xfer;
  logic [31:0] mag_fin;

  assign sign_in = in_data[31];
  assign exp_in  = in_data[30:23];
  assign mant_in = in_data[22:0];

  // Shift count only needs the low five exponent bits: |exp - 150| never exceeds 24 on the
  // normal path, so modulo-32 arithmetic on exp[4:0] (150 mod 32 = 22) gives the exact count.
  assign left_in = (exp_in >= EXP_ALIGN);
  assign cnt_in  = left_in ? (exp_in[4:0] - 5'd22) : (5'd22 - exp_in[4:0]);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Classify the incoming operand and form the immediate result for the special cases
  always_comb begin
    special    = 1'b1;
    spec_data  = '0;
    spec_flags = '0;
    if (exp_in == 8'hFF && mant_in != '0) begin
      spec_data  = 32'h8000_0000;
      spec_flags = 3'b100;
    end else if (exp_in >= EXP_SAT) begin
      if (in_data == 32'hCF00_0000) begin
        spec_data  = 32'h8000_0000;
        spec_flags = 3'b000;
      end else begin
        spec_data  = sign_in ? 32'h8000_0000 : 32'h7FFF_FFFF;
        spec_flags = 3'b010;
      end
    end else if (exp_in < MIN_EXP) begin
      spec_data  = '0;
      spec_flags = {2'b00, |{exp_in, mant_in}};
    end else begin
      special = 1'b0;
    end
  end

  // Final magnitude, with the nearest-even increment applied when enabled
  always_comb begin
`ifdef F_TO_INT_ROUND_NEAREST_EN
    mag_fin = mag_q + {31'd0, guard_q & (sticky_q | mag_q[0])};
`else
    mag_fin = mag_q;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (special) begin
            state_next = DONE;
          end else if (cnt_in == '0) begin
            state_next = SIGN;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt_q == 5'd1) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs derived from the current state
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Operand latch and one-bit-per-cycle alignment shifter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign_q   <= 1'b0;
      left_q   <= 1'b0;
      cnt_q    <= '0;
      mag_q    <= '0;
      sticky_q <= 1'b0;
`ifdef F_TO_INT_ROUND_NEAREST_EN
      guard_q  <= 1'b0;
`endif
    end else begin
      if (in_xfer) begin
        sign_q   <= sign_in;
        left_q   <= left_in;
        cnt_q    <= cnt_in;
        mag_q    <= {8'd0, 1'b1, mant_in};
        sticky_q <= 1'b0;
`ifdef F_TO_INT_ROUND_NEAREST_EN
        guard_q  <= 1'b0;
`endif
      end else if (state == SHIFT) begin
        cnt_q <= cnt_q - 5'd1;
        if (left_q) begin
          mag_q <= {mag_q[30:0], 1'b0};
        end else begin
          mag_q <= {1'b0, mag_q[31:1]};
`ifdef F_TO_INT_ROUND_NEAREST_EN
          // The most recent bit out is the guard; older ones collapse into sticky.
          guard_q  <= mag_q[0];
          sticky_q <= sticky_q | guard_q;
`else
          sticky_q <= sticky_q | mag_q[0];
`endif
        end
      end
    end
  end

  // Result registers: loaded on a special-case accept or in SIGN, frozen through DONE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      out_flags <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      if (in_xfer && special) begin
        out_data  <= spec_data;
        out_flags <= spec_flags;
      end else if (state == SIGN) begin
        out_data <= sign_q ? (~mag_fin + 32'd1) : mag_fin;
`ifdef F_TO_INT_ROUND_NEAREST_EN
        out_flags <= {2'b00, guard_q | sticky_q};
`else
        out_flags <= {2'b00, sticky_q};
`endif
      end
    end
  end

  // out_xfer is implied by the DONE -> IDLE transition; kept for readability of the handshake.
  logic out_xfer_seen;
  assign out_xfer_seen = out_xfer;

endmodule

// File: tb/tb_f_to_int.sv
// tb_f_to_int: table-driven bench for f_to_int with a scoreboard queue of expected results.
// Expected values follow F_TO_INT_ROUND_NEAREST_EN when it is defined for the build.
module tb_f_to_int;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  f_to_int dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic [2:0]  flags;
    int unsigned lat;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic [2:0]  flags;
    int unsigned lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic add(input logic [31:0] din, input logic [31:0] dout,
                     input logic [2:0] flags, input int unsigned lat);
    vec_t v;
    v.din = din; v.dout = dout; v.flags = flags; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Drive one operand; leaves time at #1 after the accepting edge
  task automatic send(input logic [31:0] d, input logic [31:0] dout,
                      input logic [2:0] flags, input int unsigned lat, input bit push);
    exp_t e;
    int unsigned w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    if (push) begin
      e.dout = dout; e.flags = flags; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Wait for a result, compare against the scoreboard, optionally hold backpressure
  task automatic collect(input string name, input int unsigned hold);
    int unsigned lat;
    exp_t e;
    logic [31:0] held;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid) in_data = $urandom;
    end
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_data"}, out_data, e.dout);
      check({name, "_flags"}, {29'd0, out_flags}, {29'd0, e.flags});
      check({name, "_latency"}, lat, e.lat);
    end
    held = out_data;
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_data"}, out_data, held);
      check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int unsigned seen;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // din, expected data, flags, edges from accept to out_valid
    add(32'h3F80_0000, 32'h0000_0001, 3'b000, 24);
    add(32'hC2F6_E979, 32'hFFFF_FF85, 3'b001, 18);
    add(32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 0);
    add(32'hCF00_0000, 32'h8000_0000, 3'b000, 0);
    add(32'hFF80_0000, 32'h8000_0000, 3'b010, 0);
    add(32'h7FC0_0000, 32'h8000_0000, 3'b100, 0);
    add(32'h7F80_0000, 32'h7FFF_FFFF, 3'b010, 0);
    add(32'hFFC0_0001, 32'h8000_0000, 3'b100, 0);
    add(32'hCF00_0001, 32'h8000_0000, 3'b010, 0);
    add(32'h4B00_0000, 32'h0080_0000, 3'b000, 1);
    add(32'hBF80_0000, 32'hFFFF_FFFF, 3'b000, 24);
    add(32'h4E80_0000, 32'h4000_0000, 3'b000, 8);
    add(32'hCEFF_FFFF, 32'h8000_0080, 3'b000, 8);
    add(32'h0000_0000, 32'h0000_0000, 3'b000, 0);
    add(32'h8000_0000, 32'h0000_0000, 3'b000, 0);
    add(32'h0000_0001, 32'h0000_0000, 3'b001, 0);
    add(32'h3E80_0000, 32'h0000_0000, 3'b001, 0);
    add(32'h4020_0000, 32'h0000_0002, 3'b001, 23);
`ifdef F_TO_INT_ROUND_NEAREST_EN
    add(32'h4060_0000, 32'h0000_0004, 3'b001, 23);
    add(32'h3F40_0000, 32'h0000_0001, 3'b001, 25);
    add(32'h3F00_0000, 32'h0000_0000, 3'b001, 25);
    add(32'hBFC0_0000, 32'hFFFF_FFFE, 3'b001, 24);
`else
    add(32'h4060_0000, 32'h0000_0003, 3'b001, 23);
    add(32'h3F40_0000, 32'h0000_0000, 3'b001, 0);
    add(32'h3F00_0000, 32'h0000_0000, 3'b001, 0);
    add(32'hBFC0_0000, 32'hFFFF_FFFF, 3'b001, 24);
`endif

    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_flags", {29'd0, out_flags}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      send(vecs[i].din, vecs[i].dout, vecs[i].flags, vecs[i].lat, 1'b1);
      collect($sformatf("vec%0d_%h", i, vecs[i].din), 0);
    end

    // Backpressure on 2^23: result frozen for five cycles
    out_ready = 1'b0;
    send(32'h4B00_0000, 32'h0080_0000, 3'b000, 1, 1'b1);
    collect("backpressure", 5);

    // Backpressure on a special case, which is valid right after the accept edge
    out_ready = 1'b0;
    send(32'hFF80_0000, 32'h8000_0000, 3'b010, 0, 1'b1);
    collect("bp_special", 3);

    // Reset ten cycles into converting 1.0: no result must ever appear
    send(32'h3F80_0000, 32'h0, 3'b000, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 32'd0);

    // Recovery after the aborted conversion
    send(32'hC2F6_E979, 32'hFFFF_FF85, 3'b001, 18, 1'b1);
    collect("after_abort", 0);

    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
